pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/execute sequencer that drives the program counter's `inc`, `load` and `reset` controls in the 16-bit CPU. It requests instruction words from instruction memory with a req/ack handshake, holds each word in an instruction register, and in a one-cycle execute slot decides between PC increment and PC load. The decision uses the C-instruction jump bits and the ALU `zr`/`ng` flags. It sits between instruction memory, the ALU flag outputs and the `PC` block, and also provides halt/resume control and a retired-instruction count.

## Interface
Parameters:
- `WIDTH`, 16, instruction and retired-count width.
- `TIMEOUT`, 15, maximum cycles `fetch_req` may wait for `imem_ack` (1..255; only used with the watchdog).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  in  1  begin or resume fetching; honoured only in IDLE or HALT.
- `halt_req`  in  1  request a stop at the next instruction boundary.
- `fetch_req`  out  1  instruction fetch request to memory.
- `imem_ack`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  WIDTH  instruction word.
- `zr`  in  1  ALU result is zero; valid during EXEC.
- `ng`  in  1  ALU result is negative; valid during EXEC.
- `pc_inc`  out  1  drives PC `inc`.
- `pc_load`  out  1  drives PC `load`.
- `pc_reset`  out  1  drives PC `reset`; active-high.
- `ir`  out  WIDTH  instruction register.
- `exec`  out  1  high during the EXEC cycle.
- `state`  out  2  IDLE=0, FETCH=1, EXEC=2, HALT=3.
- `retired`  out  WIDTH  count of EXEC cycles completed.
- `fault`  out  1  fetch watchdog expired; sticky.

## Operation
- States:
  - IDLE: goes to FETCH when `start`=1.
  - FETCH: goes to EXEC when `imem_ack`=1. On that edge, `ir` <= `imem_data`.
  - EXEC: goes to HALT if the halt latch is set, otherwise to FETCH.
  - HALT: goes to FETCH when `start`=1; the halt latch is cleared on entry to HALT.
- `fetch_req` = (state==FETCH). `exec` = (state==EXEC). Both are combinational from state.
- Jump decode:
  - For `ir[15]`=0 (A-instruction): jump=0.
  - For `ir[15]`=1 (C-instruction): jump = (`ir[2]`&`ng`) | (`ir[1]`&`zr`) | (`ir[0]`&~`ng`&~`zr`).
- In EXEC: `pc_load` = jump and `pc_inc` = ~jump. Exactly one of them is high.
- Outside EXEC, both `pc_load` and `pc_inc` are 0.
- Halt latch:
  - Set by `halt_req`=1 in any non-reset cycle.
  - Holds until HALT is entered.
  - `halt_req` in IDLE takes effect at the first EXEC after `start`.
- `retired` increments by 1 on each EXEC edge and wraps from 2^WIDTH-1 to 0.
- `start` outside IDLE/HALT is ignored. `imem_ack` outside FETCH is ignored.
- `reset`=0 sampled, regardless of state:
  - state <= IDLE; `ir`, `retired`, `fault` and the halt latch <= 0.
  - `pc_reset` register <= 1.
  - A fetch in flight is abandoned.
- `pc_reset` is registered:
  - It stays 1 for every cycle after an edge that sampled `reset`=0.
  - It clears on the first edge that samples `reset`=1.

## Timing
- Reset values: state=IDLE, `fetch_req`=0, `pc_inc`=0, `pc_load`=0, `exec`=0, `ir`=0, `retired`=0, `fault`=0, `pc_reset`=1.
- Minimum instruction period is 2 cycles: FETCH with `imem_ack` in the same cycle, then EXEC.
- PC update:
  - The PC updates on the edge that ends EXEC, which is the same edge that enters the next FETCH.
  - `fetch_req` therefore addresses the updated PC.
- `start` to first `fetch_req`: 1 cycle.
- `halt_req` and `imem_ack` in the same FETCH cycle: the fetched instruction still executes, then the block enters HALT.
- `start` and `halt_req` in the same HALT cycle: the block resumes, executes exactly one instruction, then returns to HALT.

## Configuration
- `PCSEQ_TIMEOUT_EN` defined: the fetch watchdog is compiled in.
  - An 8-bit counter clears on entry to FETCH and increments each FETCH cycle without `imem_ack`.
  - When the counter reaches `TIMEOUT`, the block sets `fault`=1 and enters HALT with no EXEC.
  - `start` from HALT retries the fetch.
  - `fault` clears only on reset.
- `PCSEQ_TIMEOUT_EN` undefined: no counter is built; `fault` is tied to 0 and FETCH waits indefinitely.

## Test plan
- Reset to first fetch: hold `reset`=0 for 3 cycles, then `start`=1 with `imem_ack` tied to 1.
  - Required: `pc_reset`=1 throughout reset and 0 one edge after release.
  - Required: `fetch_req` one cycle after `start`.
  - Required: `pc_inc` pulses every 2nd cycle.
- Jumps: `imem_data`=16'hE302 (C-instruction, JEQ) with `zr`=1 -> `pc_load`=1, `pc_inc`=0.
  - Same instruction with `zr`=0, `ng`=1 -> `pc_inc`=1.
  - `imem_data`=16'h0019 (A-instruction) -> `pc_inc`=1.
- Ack latency: `imem_ack` delayed 4 cycles.
  - Required: `fetch_req` held high for 4 cycles, `ir` unchanged until the ack edge, exactly one `exec` pulse.
- Halt/resume: `halt_req` pulse mid-FETCH.
  - Required: the current instruction retires, then state=3 with no `fetch_req`.
  - Required: `start` resumes fetching and `retired` continues from its held value.
- Watchdog (`PCSEQ_TIMEOUT_EN`, `TIMEOUT`=15): `imem_ack` never asserted.
  - Required: `fault`=1 and state=3 after 15 FETCH cycles, with no `pc_inc`/`pc_load`.
- Wrap and reset mid-operation:
  - Preload until `retired`=16'hFFFF; one more EXEC -> 16'h0000.
  - Assert `reset`=0 during FETCH -> IDLE on the next edge, `ir`=0, `fault`=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between pc_sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic             fetch_req;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;

    modport master (
        output fetch_req,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  fetch_req,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC inc/load/reset controls of the 16-bit CPU.
// Optional fetch watchdog compiled in with PCSEQ_TIMEOUT_EN; without it fault is tied low
// and FETCH waits for imem_ack indefinitely.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start
// FETCH | fetch_req high, waiting for imem_ack; ir captured on ack
// EXEC  | one-cycle execute slot, exactly one of pc_inc/pc_load high
// HALT  | stopped at an instruction boundary (halt or watchdog)
module pc_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    pc_sequencer_if.master   bus,
    input  logic             zr,
    input  logic             ng,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_reset,
    output logic [WIDTH-1:0] ir,
    output logic             exec,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] retired,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state_q;
    logic   halt_latch;
    logic   jump;

`ifdef PCSEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] wd_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
    assign fault      = 1'b0;
`endif

    // Jump decision from the C-instruction jump bits and the ALU flags.
    always_comb begin
        jump = 1'b0;
        if (ir[15]) begin
            jump = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
        end
    end

    assign bus.fetch_req = (state_q == FETCH);
    assign exec          = (state_q == EXEC);
    assign pc_load       = exec & jump;
    assign pc_inc        = exec & ~jump;
    assign state         = state_q;

    // Sequencer state, instruction register, halt latch, retired count and watchdog.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ir         <= '0;
            retired    <= '0;
            halt_latch <= 1'b0;
            pc_reset   <= 1'b1;
`ifdef PCSEQ_TIMEOUT_EN
            fault      <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            pc_reset <= 1'b0;
            // Retired is written every cycle (adding zero outside EXEC).
            retired  <= retired + {{(WIDTH-1){1'b0}}, exec};
            if (halt_req) begin
                halt_latch <= 1'b1;
            end
`ifdef PCSEQ_TIMEOUT_EN
            if (state_q != FETCH) begin
                wd_cnt <= '0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir      <= bus.imem_data;
                        state_q <= EXEC;
                    end
`ifdef PCSEQ_TIMEOUT_EN
                    else if (wd_cnt == TIMEOUT_CNT - 8'd1) begin
                        // Entering HALT clears the halt latch even when the watchdog is the cause.
                        fault      <= 1'b1;
                        state_q    <= HALT;
                        halt_latch <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                EXEC: begin
                    if (halt_latch) begin
                        state_q    <= HALT;
                        halt_latch <= 1'b0;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                HALT: begin
                    if (start) begin
                        state_q <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random traffic,
// all compared against a behavioural model of the fetch/execute rules.
module tb_pc_sequencer;

    localparam int W   = 16;
    localparam int TMO = 15;
`ifdef PCSEQ_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          zr = 1'b0;
    logic          ng = 1'b0;
    logic          pc_inc, pc_load, pc_reset, exec, fault;
    logic [W-1:0]  ir, retired;
    logic [1:0]    state;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .halt_req (halt_req),
        .bus      (bus),
        .zr       (zr),
        .ng       (ng),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .pc_reset (pc_reset),
        .ir       (ir),
        .exec     (exec),
        .state    (state),
        .retired  (retired),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 idle, 1 fetching, 2 executing, 3 halted.
    int          m_state = 0;
    logic [15:0] m_ir = 16'h0;
    int unsigned m_ret = 0;
    bit          m_fault = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_pcr = 1'b1;
    int          m_wait = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Jump taken when the ALU result class (positive / zero / negative) is selected by j bits.
    function automatic bit ref_jump(input logic [15:0] word, input bit z, input bit n);
        int cls;
        if (!word[15]) return 1'b0;
        cls = n ? 2 : (z ? 1 : 0);
        return word[cls];
    endfunction

    function automatic void model_edge();
        bit nh;
        if (!reset) begin
            m_state = 0; m_ir = 16'h0; m_ret = 0; m_fault = 0;
            m_halt = 0; m_pcr = 1; m_wait = 0;
            return;
        end
        m_pcr = 0;
        nh = m_halt | halt_req;
        case (m_state)
            0: if (start) begin m_state = 1; m_wait = 0; end
            1: begin
                if (bus.imem_ack) begin
                    m_ir = bus.imem_data;
                    m_state = 2;
                end else begin
                    m_wait++;
                    if (WD_EN && m_wait >= TMO) begin
                        m_fault = 1; m_state = 3; nh = 0;
                    end
                end
            end
            2: begin
                m_ret = (m_ret + 1) % 65536;
                if (m_halt) begin m_state = 3; nh = 0; end
                else begin m_state = 1; m_wait = 0; end
            end
            default: if (start) begin m_state = 1; m_wait = 0; end
        endcase
        m_halt = nh;
    endfunction

    // One clock: check PC controls against current inputs, clock, then check registered outputs.
    task automatic tick(input bit comb_chk = 1'b1);
        bit ex, j;
        #1;
        if (comb_chk) begin
            ex = (m_state == 2);
            j  = ex && ref_jump(m_ir, zr, ng);
            chk("pc_load", pc_load, j);
            chk("pc_inc", pc_inc, ex && !j);
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("state", state, m_state);
        chk("ir", ir, m_ir);
        chk("retired", retired, m_ret);
        chk("fault", fault, m_fault);
        chk("pc_reset", pc_reset, m_pcr);
        chk("fetch_req", bus.fetch_req, m_state == 1);
        chk("exec", exec, m_state == 2);
    endtask

    task automatic goto_fetch();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_state == 1) begin ok = 1'b1; break; end
            start = (m_state == 0 || m_state == 3);
            bus.imem_ack = 1'b1;
            tick();
        end
        start = 1'b0;
        bus.imem_ack = 1'b0;
        chk("goto_fetch_bound", ok, 1'b1);
    endtask

    task automatic run_instr(input logic [15:0] word, input bit z, input bit n, input string tag);
        goto_fetch();
        bus.imem_data = word;
        bus.imem_ack = 1'b1;
        zr = 1'b0; ng = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        zr = z; ng = n;
        #1;
        chk({tag, "_load"}, pc_load, ref_jump(word, z, n));
        chk({tag, "_inc"}, pc_inc, !ref_jump(word, z, n));
        tick();
        zr = 1'b0; ng = 1'b0;
    endtask

    initial begin
        int cnt;
        int unsigned held;
        logic [15:0] last_word;

        bus.imem_ack = 1'b0;
        bus.imem_data = 16'h0;

        // Reset held for three cycles, then released.
        tick(1'b0);
        tick(); tick();
        chk("rst_pc_reset", pc_reset, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_release_pc_reset", pc_reset, 1'b0);

        // Start with ack tied high: fetch one cycle later, pc_inc every second cycle.
        bus.imem_ack = 1'b1;
        bus.imem_data = 16'h0019;
        start = 1'b1;
        tick();
        chk("start_fetch_req", bus.fetch_req, 1'b1);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            cnt += int'(pc_inc);
            tick();
        end
        chk("inc_every_2nd", cnt, 4);
        bus.imem_ack = 1'b0;

        // Jump decode.
        run_instr(16'hE302, 1'b1, 1'b0, "jeq_taken");
        run_instr(16'hE302, 1'b0, 1'b1, "jeq_not");
        run_instr(16'h0019, 1'b1, 1'b0, "a_instr");
        run_instr(16'hE307, 1'b0, 1'b0, "jmp");
        last_word = 16'hE307;

        // Ack delayed four cycles.
        goto_fetch();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lat_fetch_req", bus.fetch_req, 1'b1);
            chk("lat_ir_hold", ir, last_word);
        end
        bus.imem_data = 16'hE304;
        bus.imem_ack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.imem_ack = 1'b0;
            cnt += int'(exec);
        end
        chk("lat_one_exec", cnt, 1);
        chk("lat_ir_new", ir, 16'hE304);

        // Halt request mid-FETCH: current instruction retires, then HALT.
        goto_fetch();
        held = m_ret;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        bus.imem_data = 16'h0001;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        chk("halt_state", state, 2'd3);
        chk("halt_retired", retired, (held + 1) % 65536);
        tick(); tick();
        chk("halt_no_fetch", bus.fetch_req, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_fetch", bus.fetch_req, 1'b1);
        bus.imem_ack = 1'b1;
        tick(); tick();
        bus.imem_ack = 1'b0;
        chk("resume_retired", retired, (held + 2) % 65536);

        // Start and halt together in HALT: exactly one instruction, then HALT again.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        bus.imem_ack = 1'b1;
        tick(); tick();
        chk("halt2_state", state, 2'd3);
        held = m_ret;
        start = 1'b1; halt_req = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b0;
        tick(); tick();
        bus.imem_ack = 1'b0;
        chk("one_shot_state", state, 2'd3);
        chk("one_shot_retired", retired, (held + 1) % 65536);

        // Retired wraps from FFFF to 0.
        goto_fetch();
        force dut.retired = 16'hFFFF;
        m_ret = 16'hFFFF;
        tick();
        release dut.retired;
        #1;
        chk("wrap_preload", retired, 16'hFFFF);
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        chk("wrap_zero", retired, 16'h0000);

        // Reset during FETCH abandons the fetch.
        goto_fetch();
        bus.imem_ack = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_mid_idle", state, 2'd0);
        chk("rst_mid_ir", ir, 16'h0);
        chk("rst_mid_fault", fault, 1'b0);
        reset = 1'b1;
        tick();

        // Fetch watchdog: imem_ack never arrives.
        goto_fetch();
        cnt = 0;
        for (int i = 0; i < TMO; i++) begin
            #1;
            cnt += int'(pc_inc | pc_load);
            tick();
        end
        chk("wd_no_pc_ctrl", cnt, 0);
        chk("wd_fault", fault, WD_EN);
        chk("wd_state", state, WD_EN ? 2'd3 : 2'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            reset         = ($urandom_range(63) != 0);
            start         = ($urandom_range(3) == 0);
            halt_req      = ($urandom_range(15) == 0);
            bus.imem_ack  = ($urandom_range(2) != 0);
            bus.imem_data = 16'($urandom);
            case ($urandom_range(2))
                0: begin zr = 1'b0; ng = 1'b0; end
                1: begin zr = 1'b1; ng = 1'b0; end
                default: begin zr = 1'b0; ng = 1'b1; end
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
